// File: rtl/sysid_check_master.sv
// Avalon-MM read master that fetches the system-ID and timestamp words and checks them
// against build-time values, with a per-read timeout and bounded retries.
module sysid_check_master #(
  parameter logic [31:0] EXPECTED_ID = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS = 32'd1525153154,
  parameter logic [7:0]  TIMEOUT_CYC = 8'd255,
  parameter logic [1:0]  MAX_RETRIES = 2'd2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        address,
  output logic        read,
  input  logic        waitrequest,
  input  logic        readdatavalid,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timed_out,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, FINISH} state_t;

  state_t     state;
  logic [7:0] timer;
  logic [1:0] retries;
  logic       in_req;
  logic       in_wait;
  logic       is_ts;
  logic       capture;

  // Data is taken either while waiting or in the accept cycle itself (zero-latency slave).
  always_comb begin
    in_req  = (state == REQ_ID)  || (state == REQ_TS);
    in_wait = (state == WAIT_ID) || (state == WAIT_TS);
    is_ts   = (state == REQ_TS)  || (state == WAIT_TS);
    capture = readdatavalid && (in_wait || (in_req && !waitrequest));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      retries   <= '0;
      address   <= 1'b0;
      read      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      id_ok     <= 1'b0;
      ts_ok     <= 1'b0;
      timed_out <= 1'b0;
      id_value  <= '0;
      ts_value  <= '0;
    end else begin
      done <= 1'b0;
      if (capture) begin
        timer <= '0;
        if (is_ts) begin
          ts_value <= readdata;
          ts_ok    <= (readdata == EXPECTED_TS);
          read     <= 1'b0;
          done     <= 1'b1;
          state    <= FINISH;
        end else begin
          id_value <= readdata;
          id_ok    <= (readdata == EXPECTED_ID);
          retries  <= '0;
          read     <= 1'b1;
          address  <= 1'b1;
          state    <= REQ_TS;
        end
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              state     <= REQ_ID;
              busy      <= 1'b1;
              read      <= 1'b1;
              address   <= 1'b0;
              id_ok     <= 1'b0;
              ts_ok     <= 1'b0;
              timed_out <= 1'b0;
              retries   <= '0;
              timer     <= '0;
            end
          end
          REQ_ID, REQ_TS: begin
            if (!waitrequest) begin
              read  <= 1'b0;
              timer <= '0;
              state <= is_ts ? WAIT_TS : WAIT_ID;
            end
          end
          WAIT_ID, WAIT_TS: begin
            // The TIMEOUT_CYC-th wait cycle is the last one in which data is still accepted.
            if (timer == TIMEOUT_CYC - 8'd1) begin
              timer <= '0;
              if (retries < MAX_RETRIES) begin
                retries <= retries + 2'd1;
                read    <= 1'b1;
                state   <= is_ts ? REQ_TS : REQ_ID;
              end else begin
                timed_out <= 1'b1;
                done      <= 1'b1;
                state     <= FINISH;
              end
            end else begin
              timer <= timer + 8'd1;
            end
          end
          FINISH: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sysid_check_master.sv
// Bench for sysid_check_master: scripted reactive Avalon slave plus an expected-output
// timeline derived from slave stall/latency scripts, compared every cycle.
`timescale 1ns/1ps
module tb_sysid_check_master;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'd1525153154;
  localparam int TO    = 4;
  localparam int MR    = 1;
  localparam int NEVER = 1000;

  logic        clock = 1'b0;
  logic        reset, start, waitrequest, readdatavalid;
  logic [31:0] readdata;
  logic        address, read, busy, done, id_ok, ts_ok, timed_out;
  logic [31:0] id_value, ts_value;

  always #5 clock = ~clock;

  sysid_check_master #(
    .EXPECTED_ID(EXP_ID),
    .EXPECTED_TS(EXP_TS),
    .TIMEOUT_CYC(8'd4),
    .MAX_RETRIES(2'd1)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .address(address), .read(read),
    .waitrequest(waitrequest), .readdatavalid(readdatavalid), .readdata(readdata),
    .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok), .timed_out(timed_out),
    .id_value(id_value), .ts_value(ts_value)
  );

  typedef struct packed {
    logic        read;
    logic        address;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic        timed_out;
    logic [31:0] id_value;
    logic [31:0] ts_value;
  } outs_t;

  outs_t act;
  assign act = {read, address, busy, done, id_ok, ts_ok, timed_out, id_value, ts_value};

  // slave script: per word, per attempt stall cycles and read latency (NEVER = no data)
  int          sc_w   [2][4];
  int          sc_lat [2][4];
  logic [31:0] sc_dat [2];
  bit          slave_clr, stray;
  logic [31:0] stray_data;
  int          att [2];
  int          n_acc [2];
  int          stall, pend;
  logic [31:0] pend_data;

  initial begin : slave
    int ad;
    waitrequest = 1'b0; readdatavalid = 1'b0; readdata = '0;
    pend = 0; stall = 0; att = '{0, 0}; n_acc = '{0, 0}; pend_data = '0;
    forever begin
      @(posedge clock); #1;
      waitrequest = 1'b0; readdatavalid = 1'b0; readdata = '0;
      if (slave_clr) begin att = '{0, 0}; n_acc = '{0, 0}; stall = 0; end
      if (reset) begin
        pend = 0; stall = 0;
      end else begin
        if (stray) begin readdatavalid = 1'b1; readdata = stray_data; end
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin readdatavalid = 1'b1; readdata = pend_data; end
        end
        if (read === 1'b1) begin
          ad = (address === 1'b1) ? 1 : 0;
          if (stall < sc_w[ad][att[ad]]) begin
            waitrequest = 1'b1;
            stall++;
          end else begin
            stall = 0;
            n_acc[ad]++;
            if (sc_lat[ad][att[ad]] == 0) begin
              readdatavalid = 1'b1; readdata = sc_dat[ad];
            end else if (sc_lat[ad][att[ad]] < NEVER) begin
              pend = sc_lat[ad][att[ad]]; pend_data = sc_dat[ad];
            end
            if (att[ad] < 3) att[ad]++;
          end
        end
      end
    end
  end

  outs_t exp_now;
  outs_t tl [0:63];
  int    tl_len, idx;
  bit    active, cmp_en;
  int    checks, passes;
  int    done_cnt, done_idx;

  task automatic set_sc(input int w, input int lid0, input int lid1, input int lts,
                        input logic [31:0] did, input logic [31:0] dts);
    for (int a = 0; a < 4; a++) begin
      sc_w[0][a] = w; sc_w[1][a] = w;
      sc_lat[0][a] = (a == 0) ? lid0 : lid1;
      sc_lat[1][a] = lts;
    end
    sc_dat[0] = did; sc_dat[1] = dts;
  endtask

  // Expected output per cycle after start (index 0 = the start cycle).
  task automatic build(input outs_t prev);
    outs_t cur;
    int    t, acc, cap;
    bit    got, fail;
    cur = prev; tl[0] = prev;
    cur.busy = 1'b1; cur.done = 1'b0;
    cur.id_ok = 1'b0; cur.ts_ok = 1'b0; cur.timed_out = 1'b0;
    t = 1; fail = 1'b0;
    for (int wd = 0; wd < 2 && !fail; wd++) begin
      got = 1'b0;
      for (int a = 0; a <= MR && !got; a++) begin
        acc = t + sc_w[wd][a];
        cur.read = 1'b1; cur.address = (wd == 1);
        for (int c = t; c <= acc; c++) tl[c] = cur;
        cur.read = 1'b0;
        if (sc_lat[wd][a] <= TO) begin
          cap = acc + sc_lat[wd][a];
          for (int c = acc + 1; c <= cap; c++) tl[c] = cur;
          if (wd == 0) begin cur.id_value = sc_dat[0]; cur.id_ok = (sc_dat[0] == EXP_ID); end
          else         begin cur.ts_value = sc_dat[1]; cur.ts_ok = (sc_dat[1] == EXP_TS); end
          t = cap + 1; got = 1'b1;
        end else begin
          for (int c = acc + 1; c <= acc + TO; c++) tl[c] = cur;
          t = acc + TO + 1;
        end
      end
      if (!got) fail = 1'b1;
    end
    if (fail) cur.timed_out = 1'b1;
    cur.done = 1'b1; tl[t] = cur;
    cur.done = 1'b0; cur.busy = 1'b0; tl[t + 1] = cur;
    tl_len = t + 2;
  endtask

  task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%h exp=%h", name, got, exp);
  endtask

  // Compare the finished cycle at negedge, then step the model past the next edge.
  task automatic next_cyc();
    logic rs;
    @(negedge clock);
    if (cmp_en) begin
      checks++;
      if (act === exp_now) passes++;
      else $display("FAIL cycle_cmp t=%0t got rd=%b ad=%b bz=%b dn=%b ido=%b tso=%b to=%b id=%h ts=%h exp rd=%b ad=%b bz=%b dn=%b ido=%b tso=%b to=%b id=%h ts=%h",
                    $time, act.read, act.address, act.busy, act.done, act.id_ok, act.ts_ok, act.timed_out,
                    act.id_value, act.ts_value, exp_now.read, exp_now.address, exp_now.busy, exp_now.done,
                    exp_now.id_ok, exp_now.ts_ok, exp_now.timed_out, exp_now.id_value, exp_now.ts_value);
    end
    @(posedge clock);
    rs = reset;
    #3;
    if (rs) begin
      exp_now = '0; active = 1'b0;
    end else if (active) begin
      if (idx < tl_len - 1) idx++;
      exp_now = tl[idx];
    end
    if (done === 1'b1) begin done_cnt++; done_idx = idx; end
  endtask

  task automatic launch();
    build(exp_now);
    slave_clr = 1'b1; active = 1'b1; idx = 0; start = 1'b1;
    done_cnt = 0; done_idx = -1;
  endtask

  task automatic run_test(input int s1, input int s2);
    int c;
    launch();
    c = 0;
    while (idx < tl_len - 1 && c < 200) begin
      next_cyc();
      c++;
      slave_clr = 1'b0;
      start = (c == s1) || (c == s2);
    end
    start = 1'b0;
    if (idx < tl_len - 1) begin
      checks++;
      $display("FAIL run_bound got=%0d exp=%0d", idx, tl_len - 1);
    end
    next_cyc(); next_cyc();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stray = 1'b0; stray_data = '0; slave_clr = 1'b0;
    cmp_en = 1'b0; exp_now = '0; active = 1'b0; idx = 0; tl_len = 1;
    checks = 0; passes = 0; done_cnt = 0; done_idx = -1;
    set_sc(0, 0, 0, 0, EXP_ID, EXP_TS);
    @(posedge clock); #3;
    cmp_en = 1'b1;
    next_cyc();
    reset = 1'b0;
    next_cyc(); next_cyc();
    check_lit("rst_read", 32'(read), 32'd0);
    check_lit("rst_busy", 32'(busy), 32'd0);
    check_lit("rst_flags", 32'({id_ok, ts_ok, timed_out, done}), 32'd0);
    check_lit("rst_id_value", id_value, 32'd0);

    // zero-latency, matching words
    set_sc(0, 0, 0, 0, EXP_ID, EXP_TS);
    run_test(-1, -1);
    check_lit("t1_done_cycle", done_idx, 32'd3);
    check_lit("t1_done_count", done_cnt, 32'd1);
    check_lit("t1_pass", 32'({id_ok, ts_ok, timed_out}), 32'b110);
    check_lit("t1_ts_value", ts_value, 32'd1525153154);

    // stale timestamp
    set_sc(0, 0, 0, 0, EXP_ID, 32'd1525153155);
    run_test(-1, -1);
    check_lit("t2_flags", 32'({id_ok, ts_ok, timed_out}), 32'b100);
    check_lit("t2_ts_value", ts_value, 32'd1525153155);

    // 5-cycle stalls, start pulses while busy and in the finish cycle
    set_sc(5, 0, 0, 0, EXP_ID, EXP_TS);
    run_test(4, 13);
    check_lit("t3_done_cycle", done_idx, 32'd13);
    check_lit("t3_done_count", done_cnt, 32'd1);
    check_lit("t3_pass", 32'({id_ok, ts_ok, timed_out}), 32'b110);

    // ID never answers
    set_sc(0, NEVER, NEVER, 0, EXP_ID, EXP_TS);
    run_test(-1, -1);
    check_lit("t4_id_reads", n_acc[0], 32'd2);
    check_lit("t4_ts_reads", n_acc[1], 32'd0);
    check_lit("t4_done_cycle", done_idx, 32'd11);
    check_lit("t4_done_count", done_cnt, 32'd1);
    check_lit("t4_timed_out", 32'(timed_out), 32'd1);

    // wrong ID, then a stray readdatavalid while idle
    set_sc(0, 0, 0, 0, 32'hDEAD_BEEF, EXP_TS);
    run_test(-1, -1);
    check_lit("tx_flags", 32'({id_ok, ts_ok, timed_out}), 32'b010);
    stray = 1'b1; stray_data = 32'h0000_0000;
    next_cyc();
    stray = 1'b0;
    next_cyc(); next_cyc();
    check_lit("stray_id_value", id_value, 32'hDEAD_BEEF);
    check_lit("stray_busy", 32'(busy), 32'd0);

    // data on the last allowed wait cycle
    set_sc(0, TO, TO, 0, EXP_ID, EXP_TS);
    run_test(-1, -1);
    check_lit("t5_id_reads", n_acc[0], 32'd1);
    check_lit("t5_done_cycle", done_idx, 32'd7);
    check_lit("t5_pass", 32'({id_ok, ts_ok, timed_out}), 32'b110);

    // reset while waiting for the timestamp
    set_sc(0, 0, 0, 3, EXP_ID, EXP_TS);
    launch();
    next_cyc();
    slave_clr = 1'b0; start = 1'b0;
    next_cyc(); next_cyc();
    reset = 1'b1;
    next_cyc();
    check_lit("t6_rst_outputs", 32'({read, busy, done, id_ok}), 32'd0);
    reset = 1'b0;
    next_cyc(); next_cyc(); next_cyc();
    check_lit("t6_no_done", done_cnt, 32'd0);
    set_sc(0, 0, 0, 0, EXP_ID, EXP_TS);
    run_test(-1, -1);
    check_lit("t6_pass", 32'({id_ok, ts_ok, timed_out}), 32'b110);
    check_lit("t6_done_cycle", done_idx, 32'd3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
